// File: rtl/pow2_range_accum_if.sv
// ----------------------------------------------------------------------------
// pow2_range_accum_if
//   Request/result handshake bundle for pow2_range_accum.
//
//   start_valid / start_ready : request handshake, lo/hi qualify the request
//   lo, hi                    : first loop index and exclusive loop bound
//   res_valid / res_ready     : result handshake
//   res, overflow             : final value and lost-bits flag, valid with res_valid
//
//   master : the requester / result consumer (drives the request and res_ready)
//   slave  : the accumulator block
// ----------------------------------------------------------------------------
interface pow2_range_accum_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
);
    logic             start_valid;
    logic             start_ready;
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res;
    logic             overflow;

    modport master (
        output start_valid, lo, hi, res_ready,
        input  start_ready, res_valid, res, overflow
    );

    modport slave (
        input  start_valid, lo, hi, res_ready,
        output start_ready, res_valid, res, overflow
    );
endinterface

// File: rtl/pow2_range_accum.sv
// ----------------------------------------------------------------------------
// pow2_range_accum
//   Sequential producer of the per-generate-block accumulator value. Walks an
//   index i over [lo, hi): the first iteration clears the accumulator, every
//   later iteration adds 2**i, and the total is finally doubled. The result is
//   (sum of 2**i for lo < i < hi) * 2 modulo 2**WIDTH, with an overflow flag
//   set when any term or the doubling lost bits.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : slave side of pow2_range_accum_if
//             (start_valid/start_ready/lo/hi request, res_valid/res_ready/
//              res/overflow result)
//
//   One request in flight; start_ready is high only while idle.
// ----------------------------------------------------------------------------
module pow2_range_accum #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    pow2_range_accum_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] lo_q,    lo_d;
    logic [IDX_W-1:0] hi_q,    hi_d;
    logic             ovf_q,   ovf_d;

    // Working values for one RUN iteration
    logic [IDX_W-1:0] idx_inc;
    logic [WIDTH:0]   term;
    logic [WIDTH:0]   sum;

    always_comb begin
        idx_inc = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        term    = {{WIDTH{1'b0}}, 1'b1} << idx_q;
        sum     = {1'b0, acc_q} + term;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    lo_d    = bus.lo;
                    hi_d    = bus.hi;
                    idx_d   = bus.lo;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    // An empty range skips straight to the doubling step
                    state_d = (bus.lo < bus.hi) ? RUN : SCALE;
                end
            end

            RUN: begin
                if (idx_q == lo_q) begin
                    acc_d = '0;
                end else if (int'(idx_q) >= WIDTH) begin
                    // 2**i does not fit in the accumulator at all
                    ovf_d = 1'b1;
                end else begin
                    acc_d = sum[WIDTH-1:0];
                    ovf_d = ovf_q | sum[WIDTH];
                end
                idx_d = idx_inc;
                // hi is exclusive; leaving here keeps i from ever wrapping
                if (idx_inc == hi_q) begin
                    state_d = SCALE;
                end
            end

            SCALE: begin
                acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                ovf_d   = ovf_q | acc_q[WIDTH-1];
                state_d = DONE;
            end

            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result outputs are gated so intermediate accumulator values never show
    always_comb begin
        bus.start_ready = (state_q == IDLE);
        bus.res_valid   = (state_q == DONE);
        bus.res         = (state_q == DONE) ? acc_q : '0;
        bus.overflow    = (state_q == DONE) & ovf_q;
    end

endmodule

// File: tb/tb_pow2_range_accum.sv
// ----------------------------------------------------------------------------
// tb_pow2_range_accum
//   Directed and randomized requests checked against an arithmetic reference
//   of the range sum, its doubling and the expected latency.
// ----------------------------------------------------------------------------
module tb_pow2_range_accum;

    localparam int W  = 16;
    localparam int IW = 5;

    logic clk;
    logic rst_n;

    int n_assert;
    int n_fail;

    pow2_range_accum_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    pow2_range_accum #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum 2**i over lo < i < hi, double, reduce modulo 2**W.
    function automatic void model(input int l, input int h, output int r, output bit o);
        longint total;
        total = 0;
        o     = 1'b0;
        for (int i = l + 1; i < h; i++) begin
            if (i >= W) o = 1'b1;
            else        total += (longint'(1) << i);
        end
        total = total * 2;
        if (total >= (longint'(1) << W)) o = 1'b1;
        r = int'(total % (longint'(1) << W));
    endfunction

    // Must be called at a negedge with the block idle; returns at a negedge
    // with the block idle again. hold = cycles res_ready stays low in DONE.
    // chain keeps start_valid asserted with (nl, nh) while busy.
    task automatic do_req(input logic [IW-1:0] l, input logic [IW-1:0] h, input int hold,
                          input bit chain, input logic [IW-1:0] nl, input logic [IW-1:0] nh);
        int exp_res;
        bit exp_ovf;
        int exp_lat;
        int k;
        model(int'(l), int'(h), exp_res, exp_ovf);
        exp_lat = (l < h) ? (int'(h) - int'(l) + 1) : 1;

        bus.start_valid = 1'b1;
        bus.lo          = l;
        bus.hi          = h;
        bus.res_ready   = (hold == 0);
        check("start_ready_idle", 32'(bus.start_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (chain) begin
            bus.lo = nl;
            bus.hi = nh;
        end else begin
            bus.start_valid = 1'b0;
            bus.lo          = IW'($urandom);
            bus.hi          = IW'($urandom);
        end

        k = 0;
        while (!bus.res_valid && k < 100) begin
            check("start_ready_busy", 32'(bus.start_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("res", 32'(bus.res), 32'(exp_res));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));

        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_res", 32'(bus.res), 32'(exp_res));
            check("hold_overflow", 32'(bus.overflow), 32'(exp_ovf));
            check("hold_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("res_valid_drop", 32'(bus.res_valid), 32'd0);
        check("start_ready_back", 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.lo          = '0;
        bus.hi          = '0;
        bus.res_ready   = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res", 32'(bus.res), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(5'd5,  5'd10, 0, 1'b0, 5'd0, 5'd0);
        do_req(5'd0,  5'd16, 0, 1'b0, 5'd0, 5'd0);
        do_req(5'd3,  5'd3,  0, 1'b0, 5'd0, 5'd0);
        do_req(5'd9,  5'd2,  0, 1'b0, 5'd0, 5'd0);
        do_req(5'd14, 5'd18, 0, 1'b0, 5'd0, 5'd0);

        // Stalled consumer, with a second request waiting on start_valid
        do_req(5'd5,  5'd10, 3, 1'b1, 5'd7, 5'd12);
        check("held_valid", 32'(bus.start_valid), 32'd1);
        do_req(5'd7,  5'd12, 0, 1'b0, 5'd0, 5'd0);

        // Reset in the middle of RUN
        bus.start_valid = 1'b1;
        bus.lo          = 5'd5;
        bus.hi          = 5'd10;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_start_ready", 32'(bus.start_ready), 32'd1);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_res", 32'(bus.res), 32'd0);
        check("abort_overflow", 32'(bus.overflow), 32'd0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus.res_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(bus.res_valid), 32'd0);
        end
        do_req(5'd5, 5'd10, 0, 1'b0, 5'd0, 5'd0);

        // Randomized ranges and consumer stalls
        for (int n = 0; n < 24; n++) begin
            logic [IW-1:0] rl;
            logic [IW-1:0] rh;
            rl = IW'($urandom_range(0, 31));
            rh = IW'($urandom_range(0, 31));
            do_req(rl, rh, int'($urandom_range(0, 2)), 1'b0, 5'd0, 5'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
